// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared single-precision field widths, integer limits, FSM states
// Revision : 1.0
// ============================================================================
package fp_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int INT_W   = 32;
    localparam int SHCNT_W = 5;

    localparam logic [EXP_W-1:0] EXP_BIAS       = 8'd127;
    localparam logic [EXP_W-1:0] EXP_MAX        = 8'hFF;
    localparam logic [EXP_W-1:0] SHIFT_BASE_EXP = 8'd150;
    localparam logic [EXP_W-1:0] OVF_EXP        = 8'd158;

    localparam logic [INT_W-1:0] INT_MAX     = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN     = 32'h8000_0000;
    localparam logic [INT_W-1:0] FP_NEG_2P31 = 32'hCF00_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // How FINISH should form the result, decided once at accept time
    typedef enum logic [2:0] {
        KIND_NUM  = 3'd0,
        KIND_ZERO = 3'd1,
        KIND_OVF  = 3'd2,
        KIND_MIN  = 3'd3,
        KIND_NAN  = 3'd4
    } kind_t;

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module   : fp_classify
// Brief    : Combinational IEEE-754 single-precision operand classifier
// Revision : 1.0
// ============================================================================
module fp_classify
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0]  exponent,
    input  logic [FRAC_W-1:0] fraction,
    output logic              is_zero,
    output logic              is_denorm,
    output logic              is_inf,
    output logic              is_nan,
    output logic              is_normal
);

    logic w_exp_zero;
    logic w_exp_max;
    logic w_frac_zero;

    assign w_exp_zero  = (exponent == '0);
    assign w_exp_max   = (exponent == EXP_MAX);
    assign w_frac_zero = (fraction == '0);

    assign is_zero   = w_exp_zero &  w_frac_zero;
    assign is_denorm = w_exp_zero & ~w_frac_zero;
    assign is_inf    = w_exp_max  &  w_frac_zero;
    assign is_nan    = w_exp_max  & ~w_frac_zero;
    assign is_normal = ~w_exp_zero & ~w_exp_max;

endmodule
`default_nettype wire

// File: rtl/fp_to_int.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_int
// Brief    : Serial float32 -> int32 converter, round toward zero, with flags
// Revision : 1.0
// ============================================================================
module fp_to_int
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] result,
    output logic             overflow,
    output logic             invalid,
    output logic             inexact
);

    logic                w_sign;
    logic [EXP_W-1:0]    w_exp;
    logic [FRAC_W-1:0]   w_frac;
    logic [FRAC_W:0]     w_mant;
    logic                w_is_zero;
    logic                w_is_denorm;
    logic                w_is_inf;
    logic                w_is_nan;
    logic                w_is_normal;

    kind_t               w_kind;
    logic                w_left;
    logic                w_sticky0;
    logic [SHCNT_W-1:0]  w_shift_n;
    logic [EXP_W-1:0]    w_rdist;
    logic [EXP_W-1:0]    w_ldist;

    state_t              r_state;
    kind_t               r_kind;
    logic                r_sign;
    logic                r_left;
    logic                r_sticky;
    logic [SHCNT_W-1:0]  r_cnt;
    logic [INT_W-1:0]    r_work;
    logic [INT_W-1:0]    r_result;
    logic                r_overflow;
    logic                r_invalid;
    logic                r_inexact;
    logic                r_out_valid;

    assign w_sign  = x[EXP_W+FRAC_W +: SIGN_W];
    assign w_exp   = x[FRAC_W +: EXP_W];
    assign w_frac  = x[FRAC_W-1:0];
    assign w_mant  = {(w_exp != '0), w_frac};
    assign w_rdist = SHIFT_BASE_EXP - w_exp;
    assign w_ldist = w_exp - SHIFT_BASE_EXP;

    fp_classify u_classify (
        .exponent  (w_exp),
        .fraction  (w_frac),
        .is_zero   (w_is_zero),
        .is_denorm (w_is_denorm),
        .is_inf    (w_is_inf),
        .is_nan    (w_is_nan),
        .is_normal (w_is_normal)
    );

    // Only operands that can land inside int32 with a nonzero value take the shifter
    always_comb begin
        w_kind    = KIND_NUM;
        w_left    = 1'b0;
        w_sticky0 = 1'b0;
        w_shift_n = '0;
        if (w_is_nan) begin
            w_kind = KIND_NAN;
        end else if (w_is_inf || w_exp >= OVF_EXP) begin
            w_kind = (x == FP_NEG_2P31) ? KIND_MIN : KIND_OVF;
        end else if (w_is_zero) begin
            w_kind = KIND_ZERO;
        end else if (w_is_denorm) begin
            w_kind    = KIND_ZERO;
            w_sticky0 = 1'b1;
        end else if (w_is_normal && w_exp < EXP_BIAS) begin
            w_kind    = KIND_ZERO;
            w_sticky0 = 1'b1;
        end else if (w_exp < SHIFT_BASE_EXP) begin
            w_shift_n = w_rdist[SHCNT_W-1:0];
        end else begin
            w_left    = 1'b1;
            w_shift_n = w_ldist[SHCNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_kind      <= KIND_NUM;
            r_sign      <= 1'b0;
            r_left      <= 1'b0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_work      <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_invalid   <= 1'b0;
            r_inexact   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_kind   <= w_kind;
                        r_sign   <= w_sign;
                        r_left   <= w_left;
                        r_sticky <= w_sticky0;
                        r_cnt    <= w_shift_n;
                        r_work   <= {{(INT_W-FRAC_W-1){1'b0}}, w_mant};
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        r_state <= FINISH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_left) begin
                            r_work <= r_work << 1;
                        end else begin
                            r_work   <= r_work >> 1;
                            r_sticky <= r_sticky | r_work[0];
                        end
                    end
                end
                FINISH: begin
                    r_out_valid <= 1'b1;
                    r_overflow  <= 1'b0;
                    r_invalid   <= 1'b0;
                    r_inexact   <= 1'b0;
                    r_state     <= DONE;
                    case (r_kind)
                        KIND_NAN: begin
                            r_result  <= INT_MAX;
                            r_invalid <= 1'b1;
                        end
                        KIND_OVF: begin
                            r_result   <= r_sign ? INT_MIN : INT_MAX;
                            r_overflow <= 1'b1;
                        end
                        KIND_MIN: begin
                            r_result <= INT_MIN;
                        end
                        KIND_ZERO: begin
                            r_result  <= '0;
                            r_inexact <= r_sticky;
                        end
                        default: begin
                            r_result  <= r_sign ? (~r_work + 1'b1) : r_work;
                            r_inexact <= r_sticky;
                        end
                    endcase
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign invalid   = r_invalid;
    assign inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_to_int
// Brief    : Self-checking bench for fp_to_int against an arithmetic model
// Revision : 1.0
// ============================================================================
module tb_fp_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        invalid;
    logic        inexact;

    int n_vec = 0;
    int n_err = 0;

    fp_to_int dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    // Value-level model: scale the significand by 2^(e-150), truncate, range-check as int
    function automatic void ref_model(input logic [31:0] v, output logic [31:0] r,
                                      output logic [2:0] fl, output int lat);
        int     e;
        int     sh;
        longint m;
        longint mag;
        longint val;
        logic   ex;
        e  = int'(v[30:23]);
        m  = longint'(v[22:0]);
        if (e != 0) m = m + (longint'(1) << 23);
        r  = 32'h0;
        fl = 3'b000;
        ex = 1'b0;
        if (e >= 127 && e <= 149)      lat = 150 - e + 2;
        else if (e >= 150 && e <= 157) lat = e - 150 + 2;
        else                           lat = 2;
        if (e == 255 && v[22:0] != 23'd0) begin
            r  = 32'h7FFF_FFFF;
            fl = 3'b010;
        end else begin
            if (e == 255) begin
                mag = longint'(1) << 40;
            end else if (e >= 150) begin
                sh  = e - 150;
                mag = (sh > 40) ? (longint'(1) << 40) : (m << sh);
            end else begin
                sh = 150 - e;
                if (sh >= 32) begin
                    mag = 0;
                    ex  = (m != 0);
                end else begin
                    mag = m >> sh;
                    ex  = ((m & ((longint'(1) << sh) - 1)) != 0);
                end
            end
            val = v[31] ? -mag : mag;
            if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
                fl = 3'b100;
                r  = v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                r  = val[31:0];
                fl = {2'b00, ex};
            end
        end
    endfunction

    // Called just after a rising edge; returns outputs sampled on the first out_valid cycle
    task automatic do_op(input logic [31:0] xv, output logic [31:0] r, output logic [2:0] fl,
                         output int lat, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) ok = 1'b0;
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = $urandom;
        lat      = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) ok = 1'b0;
        r  = result;
        fl = {overflow, invalid, inexact};
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = 32'h0;
        #12;
        n_vec++;
        if ({in_ready, out_valid, result, overflow, invalid, inexact} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h fl=%b, want rdy=1 vld=0 res=0 fl=000",
                     in_ready, out_valid, result, {overflow, invalid, inexact});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] xs [15]  = '{32'h40490FDB, 32'hC2F60000, 32'h4B800000, 32'h4F000000,
                                  32'hCF000000, 32'hFF800000, 32'h7FC00000, 32'h3F000000,
                                  32'h00000001, 32'h80000000, 32'h4EFFFFFF, 32'h3F800000,
                                  32'hCF000001, 32'h7F800000, 32'hBFC00000};
        logic [31:0] ers [15] = '{32'd3, 32'hFFFFFF85, 32'd16777216, 32'h7FFFFFFF,
                                  32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h0,
                                  32'h0, 32'h0, 32'h7FFFFF80, 32'd1,
                                  32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [2:0]  efl [15] = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b000, 3'b100, 3'b010, 3'b001,
                                  3'b001, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b001};
        int          elt [15] = '{24, 19, 3, 2, 2, 2, 2, 2, 2, 2, 9, 25, 2, 2, 25};
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        bit          ok;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            do_op(xs[i], r, fl, lat, ok);
            n_vec++;
            if (!ok || r !== ers[i] || fl !== efl[i] || lat != elt[i]) begin
                n_err++;
                $display("FAIL directed x=%h: got res=%h fl=%b lat=%0d ok=%0d, want res=%h fl=%b lat=%0d",
                         xs[i], r, fl, lat, ok, ers[i], efl[i], elt[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        logic [31:0] v, r, er;
        logic [2:0]  fl, efl;
        int          lat, elat, sel, e;
        bit          ok;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      e = 0;
            else if (sel == 1) e = 255;
            else               e = int'($urandom_range(120, 160));
            v = {1'($urandom), 8'(e), 23'($urandom)};
            if ($urandom_range(0, 5) == 0) v[22:0] = 23'd0;
            ref_model(v, er, efl, elat);
            do_op(v, r, fl, lat, ok);
            n_vec++;
            if (!ok || r !== er || fl !== efl || lat != elat) begin
                n_err++;
                $display("FAIL random x=%h: got res=%h fl=%b lat=%0d ok=%0d, want res=%h fl=%b lat=%0d",
                         v, r, fl, lat, ok, er, efl, elat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        bit          ok;
        bit          seen;
        out_ready = 1'b0;
        do_op(32'hC2F60000, r, fl, lat, ok);
        n_vec++;
        if (!ok || r !== 32'hFFFFFF85 || fl !== 3'b000) begin
            n_err++;
            $display("FAIL bp_first: got res=%h fl=%b ok=%0d, want res=ffffff85 fl=000", r, fl, ok);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x        = 32'h3F800000;
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid, in_ready, result, overflow, invalid, inexact} !== {2'b10, 32'hFFFFFF85, 3'b000}) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got vld=%b rdy=%b res=%h, want vld=1 rdy=0 res=ffffff85",
                         i, out_valid, in_ready, result);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL bp_ignored_input: got spurious out_valid=1, want 0");
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
        bit          ok;
        bit          seen;
        out_ready = 1'b1;
        x         = 32'h40490FDB;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        n_vec++;
        if ({in_ready, out_valid, result, overflow, invalid, inexact} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_shift: got rdy=%b vld=%b res=%h fl=%b, want rdy=1 vld=0 res=0 fl=000",
                     in_ready, out_valid, result, {overflow, invalid, inexact});
        end
        @(posedge clk); #1;
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_shift_discard: got out_valid=1 after release, want 0");
        end
        do_op(32'h3F800000, r, fl, lat, ok);
        n_vec++;
        if (!ok || r !== 32'd1 || fl !== 3'b000 || lat != 25) begin
            n_err++;
            $display("FAIL reset_next_op: got res=%h fl=%b lat=%0d ok=%0d, want res=1 fl=000 lat=25",
                     r, fl, lat, ok);
        end
        @(posedge clk); #1;

        // Reset while a result is parked in DONE
        out_ready = 1'b0;
        do_op(32'h42280000, r, fl, lat, ok);
        rst = 1'b0;
        #2;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_done: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=0",
                     out_valid, in_ready, result);
        end
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_done_discard: got out_valid=1 after release, want 0");
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v, r, er;
        logic [2:0]  fl, efl;
        int          lat, elat;
        bit          ok;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            v = {1'($urandom), 8'($urandom_range(125, 159)), 23'($urandom)};
            ref_model(v, er, efl, elat);
            do_op(v, r, fl, lat, ok);
            n_vec++;
            if (!ok || r !== er || fl !== efl || lat != elat) begin
                n_err++;
                $display("FAIL b2b x=%h: got res=%h fl=%b lat=%0d ok=%0d, want res=%h fl=%b lat=%0d",
                         v, r, fl, lat, ok, er, efl, elat);
            end
            @(posedge clk); #1;
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_handshake: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_midop;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
